// File: rtl/fifo_arb_pkg.sv
// Shared defaults and sizing helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int DEPTH_DEF   = 8;

    // Width needed to count 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    // Walk the requesters starting at ptr and keep only the first hit.
    always_comb begin : pick
        int idx;
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter feeding one downstream FIFO write port. Tracks FIFO
// occupancy (committed plus in-flight writes) so it never overfills the FIFO.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            in_req,
    input  logic [NUM_REQ*DATA_W-1:0]     in_data,
    input  logic                          in_fifo_read_ctrl,
    input  logic                          in_fifo_is_empty,
    output logic [NUM_REQ-1:0]            out_grant,
    output logic                          out_fifo_write_ctrl,
    output logic [DATA_W-1:0]             out_fifo_write_data,
    output logic [occ_width(DEPTH)-1:0]   out_occupancy
);

    localparam int                OCC_W   = occ_width(DEPTH);
    localparam int                PTR_W   = $clog2(NUM_REQ);
    localparam logic [OCC_W-1:0]  DEPTH_C = OCC_W'(DEPTH);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_valid;
    logic               read_counted;
    logic [OCC_W-1:0]   occ_after_read;
    logic [OCC_W-1:0]   occ_next;
    logic               win;
    logic [DATA_W-1:0]  win_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req   (in_req),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Space check uses occupancy after this edge's read; then select winner data and next pointer.
    always_comb begin
        read_counted   = in_fifo_read_ctrl && !in_fifo_is_empty && (out_occupancy != '0);
        occ_after_read = out_occupancy - OCC_W'(read_counted);
        win            = pick_valid && (occ_after_read < DEPTH_C);
        occ_next       = occ_after_read + OCC_W'(win);
        win_data       = '0;
        ptr_next       = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                win_data = win_data | in_data[i*DATA_W +: DATA_W];
                if (win) begin
                    ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    // Register the grant pulse, write strobe/data, occupancy and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_grant           <= '0;
            out_fifo_write_ctrl <= 1'b0;
            out_fifo_write_data <= '0;
            out_occupancy       <= '0;
            ptr                 <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            out_grant           <= win ? pick_grant : '0;
            out_fifo_write_ctrl <= win;
            if (win) begin
                out_fifo_write_data <= win_data;
            end
            out_occupancy       <= occ_next;
            ptr                 <= ptr_next;
        end
    end

endmodule
